// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-to-AXI3 bridge: transaction IDs, FSM
// state encodings, fixed AXI attributes and the word-match helper used by
// the read-after-write hazard check.
package sram_axi_bridge_pkg;

  localparam logic [3:0] ID_INST   = 4'd0;
  localparam logic [3:0] ID_DATA   = 4'd1;

  // Single-beat INCR transfers with normal, non-cacheable attributes.
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ADDR = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_SEND = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  // Two byte addresses hit the same 32-bit word (callers pass addr[31:2]).
  function automatic logic same_word(input logic [29:0] a, input logic [29:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/sram_axi_bridge_wr_ch.sv
// Write channel sequencer of the SRAM-to-AXI3 bridge. Issues one single-beat
// write at a time: AW and W are raised together and each drops on its own
// handshake; the B response then returns the FSM to idle. Busy state and the
// pending address are exported for the read-after-write hazard check.
module sram_axi_bridge_wr_ch
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] wdata_i,
  input  logic        awready_i,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic        awvalid_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        wvalid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        busy_o,
  output logic        resp_o
);

  wr_state_e   state_q;
  logic        aw_done_q, w_done_q;
  logic        awvalid_q, wvalid_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;

  logic aw_hs, w_hs, aw_fin, w_fin;

  assign aw_hs  = awvalid_q && awready_i;
  assign w_hs   = wvalid_q && wready_i;
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;

  // Write FSM: latch the request, drive AW/W until both handshake, await B.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses <= so every register sees pre-edge values;
      // a blocking = here would make later reads in this block see new values.
      state_q   <= WR_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        WR_IDLE: begin
          if (start_i) begin
            addr_q    <= addr_i;
            size_q    <= size_i;
            wstrb_q   <= wstrb_i;
            wdata_q   <= wdata_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= WR_SEND;
          end
        end
        WR_SEND: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          // The flag clears below override the sets above in the exit cycle.
          if (aw_fin && w_fin) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid_i) state_q <= WR_IDLE;
        end
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  assign awvalid_o = awvalid_q;
  assign awaddr_o  = addr_q;
  assign awsize_o  = {1'b0, size_q};
  assign wvalid_o  = wvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign busy_o    = (state_q != WR_IDLE);
  assign resp_o    = (state_q == WR_RESP);

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's instruction and data SRAM-like ports onto one AXI3
// master. Reads share the AR channel (data has priority), writes are
// sequenced by sram_axi_bridge_wr_ch, and R/B responses are routed back by ID.
// Each SRAM port keeps at most one transaction outstanding.
// Build option BRIDGE_RAW_ADDR_CHECK_EN: reads stall only when their word
// address matches the pending write; otherwise any pending write stalls reads.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data load/store port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_e   rd_state_q;
  logic        arvalid_q;
  logic [31:0] araddr_q;
  logic [1:0]  arsize_q;
  logic [3:0]  arid_q;
  logic        inst_busy_q, data_busy_q;

  logic wr_busy, wr_resp;
  logic inst_hazard, data_hazard;
  logic data_rd_go, inst_rd_go, data_wr_go;

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
  assign inst_hazard = wr_busy && same_word(inst_sram_addr[31:2], awaddr[31:2]);
  assign data_hazard = wr_busy && same_word(data_sram_addr[31:2], awaddr[31:2]);
`else
  assign inst_hazard = wr_busy;
  assign data_hazard = wr_busy;
`endif

  // Data reads win arbitration; writes need an idle data port and write FSM.
  assign data_rd_go = (rd_state_q == RD_IDLE) && data_sram_req && !data_sram_wr
                      && !data_busy_q && !data_hazard;
  assign inst_rd_go = (rd_state_q == RD_IDLE) && inst_sram_req && !inst_busy_q
                      && !inst_hazard && !data_rd_go;
  assign data_wr_go = data_sram_req && data_sram_wr && !data_busy_q && !wr_busy;

  assign inst_sram_addr_ok = inst_rd_go;
  assign data_sram_addr_ok = data_rd_go || data_wr_go;

  assign inst_sram_data_ok = rvalid && (rid == ID_INST);
  assign data_sram_data_ok = (rvalid && (rid == ID_DATA)) || (bvalid && wr_resp);
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  // Read FSM: register the winning request and hold AR stable until arready.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      arid_q     <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (data_rd_go) begin
            araddr_q   <= data_sram_addr;
            arsize_q   <= data_sram_size;
            arid_q     <= ID_DATA;
            arvalid_q  <= 1'b1;
            rd_state_q <= RD_ADDR;
          end else if (inst_rd_go) begin
            araddr_q   <= inst_sram_addr;
            arsize_q   <= inst_sram_size;
            arid_q     <= ID_INST;
            arvalid_q  <= 1'b1;
            rd_state_q <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // Per-port outstanding flags: set on acceptance, cleared on data_ok.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_busy_q <= 1'b0;
      data_busy_q <= 1'b0;
    end else begin
      if (inst_rd_go)             inst_busy_q <= 1'b1;
      else if (inst_sram_data_ok) inst_busy_q <= 1'b0;
      if (data_rd_go || data_wr_go) data_busy_q <= 1'b1;
      else if (data_sram_data_ok)   data_busy_q <= 1'b0;
    end
  end

  sram_axi_bridge_wr_ch u_wr_ch (
    .clk       (clk),
    .reset     (reset),
    .start_i   (data_wr_go),
    .addr_i    (data_sram_addr),
    .size_i    (data_sram_size),
    .wstrb_i   (data_sram_wstrb),
    .wdata_i   (data_sram_wdata),
    .awready_i (awready),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .awvalid_o (awvalid),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .wvalid_o  (wvalid),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .busy_o    (wr_busy),
    .resp_o    (wr_resp)
  );

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = {1'b0, arsize_q};
  assign arvalid = arvalid_q;
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign rready  = 1'b1;

  assign awid    = ID_DATA;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;
  assign bready  = 1'b1;

  // Inputs the bridge deliberately ignores (fetch port never writes, single
  // beat transfers, responses routed by rid / write FSM state only).
  logic unused_ok;
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: inputs change 1 time unit after the
// rising edge, outputs are checked 2 units later, well clear of either edge.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_cmp  = 0;
  int n_fail = 0;
  logic exp_far;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    exp_far = 1'b1;
`else
    exp_far = 1'b0;
`endif
    reset = 1'b1;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    tick(); tick();
    settle();

    // Reset state and fixed attributes
    checkb("rst_arvalid", arvalid, 1'b0);
    checkb("rst_awvalid", awvalid, 1'b0);
    checkb("rst_wvalid", wvalid, 1'b0);
    checkb("rst_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    checkb("rst_data_addr_ok", data_sram_addr_ok, 1'b0);
    checkb("rst_data_ok", data_sram_data_ok, 1'b0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("ar_attr", 32'({arlen, arburst, arlock, arcache, arprot}), 32'h200);
    check("aw_attr", 32'({awlen, awburst, awlock, awcache, awprot}), 32'h200);
    check("aw_w_ids", 32'({awid, wid}), 32'h11);
    checkb("wlast", wlast, 1'b1);
    checkb("rready", rready, 1'b1);
    checkb("bready", bready, 1'b1);

    // Instruction read, minimum latency
    tick(); reset = 0;
    tick();
    inst_sram_req = 1; inst_sram_size = 2'd2; inst_sram_addr = 32'h1c00_0000;
    settle();
    checkb("t1_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    checkb("t1_arvalid_c0", arvalid, 1'b0);
    tick();
    inst_sram_req = 0; arready = 1;
    settle();
    checkb("t1_arvalid", arvalid, 1'b1);
    check("t1_araddr", araddr, 32'h1c00_0000);
    check("t1_arid", 32'(arid), 32'd0);
    check("t1_arsize", 32'(arsize), 32'd2);
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h0280_0c0c;
    settle();
    checkb("t1_inst_data_ok", inst_sram_data_ok, 1'b1);
    check("t1_inst_rdata", inst_sram_rdata, 32'h0280_0c0c);
    checkb("t1_data_data_ok", data_sram_data_ok, 1'b0);
    checkb("t1_arvalid_done", arvalid, 1'b0);
    tick();
    rvalid = 0;

    // Simultaneous instruction and data reads: data wins
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0004;
    data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 32'h2000;
    settle();
    checkb("t2_data_addr_ok", data_sram_addr_ok, 1'b1);
    checkb("t2_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    tick();
    data_sram_req = 0; arready = 1;
    settle();
    checkb("t2_arvalid", arvalid, 1'b1);
    check("t2_arid", 32'(arid), 32'd1);
    check("t2_araddr", araddr, 32'h2000);
    checkb("t2_inst_wait", inst_sram_addr_ok, 1'b0);
    tick();
    arready = 0;
    settle();
    checkb("t2_inst_addr_ok_late", inst_sram_addr_ok, 1'b1);
    tick();
    inst_sram_req = 0; arready = 1; rvalid = 1; rid = 4'd1; rdata = 32'hdead_beef;
    settle();
    checkb("t2_data_data_ok", data_sram_data_ok, 1'b1);
    check("t2_data_rdata", data_sram_rdata, 32'hdead_beef);
    checkb("t2_inst_no_ok", inst_sram_data_ok, 1'b0);
    check("t2_arid_inst", 32'(arid), 32'd0);
    check("t2_araddr_inst", araddr, 32'h1c00_0004);
    tick();
    arready = 0; rid = 4'd0; rdata = 32'h1122_3344;
    settle();
    checkb("t2_inst_data_ok", inst_sram_data_ok, 1'b1);
    checkb("t2_data_quiet", data_sram_data_ok, 1'b0);
    checkb("t2_arvalid_done", arvalid, 1'b0);
    tick();
    rvalid = 0;

    // Write with late awready and immediate wready
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h100; data_sram_size = 2'd2;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'ha5a5_a5a5;
    settle();
    checkb("t3_addr_ok", data_sram_addr_ok, 1'b1);
    tick();
    data_sram_req = 0; wready = 1;
    settle();
    checkb("t3_awvalid_c1", awvalid, 1'b1);
    checkb("t3_wvalid_c1", wvalid, 1'b1);
    check("t3_awaddr", awaddr, 32'h100);
    check("t3_wdata", wdata, 32'ha5a5_a5a5);
    check("t3_wstrb", 32'(wstrb), 32'hf);
    check("t3_awsize", 32'(awsize), 32'd2);
    tick();
    wready = 0;
    settle();
    checkb("t3_wvalid_c2", wvalid, 1'b0);
    checkb("t3_awvalid_c2", awvalid, 1'b1);
    tick();
    awready = 1;
    settle();
    checkb("t3_awvalid_c3", awvalid, 1'b1);
    tick();
    awready = 0;
    settle();
    checkb("t3_awvalid_c4", awvalid, 1'b0);
    checkb("t3_no_early_ok", data_sram_data_ok, 1'b0);
    tick();
    bvalid = 1;
    settle();
    checkb("t3_data_ok", data_sram_data_ok, 1'b1);
    tick();
    bvalid = 0;

    // Read-after-write hazard
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h100; data_sram_size = 2'd1;
    data_sram_wstrb = 4'h3; data_sram_wdata = 32'h0000_beef;
    settle();
    checkb("t4_wr_addr_ok", data_sram_addr_ok, 1'b1);
    tick();
    data_sram_wr = 0; data_sram_size = 2'd2;
    inst_sram_req = 1; inst_sram_addr = 32'h200;
    awready = 1; wready = 1;
    settle();
    checkb("t4_rd_stall_send", data_sram_addr_ok, 1'b0);
    checkb("t4_inst_far", inst_sram_addr_ok, exp_far);
    check("t4_awsize", 32'(awsize), 32'd1);
    check("t4_wstrb", 32'(wstrb), 32'h3);
    inst_sram_addr = 32'h102;
    #1;
    checkb("t4_inst_same_word", inst_sram_addr_ok, 1'b0);
    inst_sram_req = 0;
    tick();
    awready = 0; wready = 0;
    settle();
    checkb("t4_rd_stall_resp", data_sram_addr_ok, 1'b0);
    checkb("t4_awvalid_off", awvalid, 1'b0);
    checkb("t4_wvalid_off", wvalid, 1'b0);
    tick();
    bvalid = 1;
    settle();
    checkb("t4_wr_data_ok", data_sram_data_ok, 1'b1);
    checkb("t4_rd_stall_b", data_sram_addr_ok, 1'b0);
    tick();
    bvalid = 0;
    settle();
    checkb("t4_rd_go", data_sram_addr_ok, 1'b1);
    tick();
    data_sram_req = 0; arready = 1;
    settle();
    checkb("t4_arvalid", arvalid, 1'b1);
    check("t4_araddr", araddr, 32'h100);
    check("t4_arid", 32'(arid), 32'd1);
    tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h0000_beef;
    settle();
    checkb("t4_rd_data_ok", data_sram_data_ok, 1'b1);
    tick();
    rvalid = 0;

    // arready held low: AR fields stay stable
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0010; inst_sram_size = 2'd2;
    settle();
    checkb("t5_addr_ok", inst_sram_addr_ok, 1'b1);
    tick();
    inst_sram_req = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      checkb("t5_arvalid_hold", arvalid, 1'b1);
      check("t5_araddr_hold", araddr, 32'h1c00_0010);
      check("t5_arid_hold", 32'(arid), 32'd0);
      check("t5_arsize_hold", 32'(arsize), 32'd2);
      tick();
    end
    arready = 1;
    settle();
    checkb("t5_arvalid_hs", arvalid, 1'b1);
    tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'hcafe_f00d;
    settle();
    checkb("t5_inst_data_ok", inst_sram_data_ok, 1'b1);
    check("t5_inst_rdata", inst_sram_rdata, 32'hcafe_f00d);
    checkb("t5_arvalid_done", arvalid, 1'b0);
    tick();
    rvalid = 0;

    // Reset while the write is in WR_SEND
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h300;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'h1234_5678;
    settle();
    checkb("t6_addr_ok", data_sram_addr_ok, 1'b1);
    tick();
    data_sram_req = 0;
    settle();
    checkb("t6_awvalid_pre", awvalid, 1'b1);
    checkb("t6_wvalid_pre", wvalid, 1'b1);
    reset = 1;
    tick();
    reset = 0; bvalid = 1;
    settle();
    checkb("t6_awvalid_rst", awvalid, 1'b0);
    checkb("t6_wvalid_rst", wvalid, 1'b0);
    checkb("t6_arvalid_rst", arvalid, 1'b0);
    checkb("t6_stray_b", data_sram_data_ok, 1'b0);
    tick();
    bvalid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkb("t6_no_data_ok", data_sram_data_ok, 1'b0);
      checkb("t6_no_inst_ok", inst_sram_data_ok, 1'b0);
      tick();
    end
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h400;
    inst_sram_req = 1; inst_sram_addr = 32'h500;
    settle();
    checkb("t6_wr_idle", data_sram_addr_ok, 1'b1);
    checkb("t6_rd_idle", inst_sram_addr_ok, 1'b1);
    data_sram_req = 0; inst_sram_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

Converts the CPU's two SRAM-like ports (instruction fetch, data load/store) into one AXI3 master port, arbitrating the shared read channel and sequencing the write channels. It sits between the pipeline (pre-IF/IF and EX/MEM) and the top-level AXI interconnect. Handshakes on the SRAM side use the `req`/`addr_ok`/`data_ok` protocol that the fetch stages already use.

## Interface
- No parameters. Fixed AXI attributes come from `mycpu.h`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `inst_sram_req/wr/size/addr/wstrb/wdata` in 1/1/2/32/4/32: fetch request. `wr` is always 0.
- `inst_sram_addr_ok`, `inst_sram_data_ok` out 1: request accepted; read data returned.
- `inst_sram_rdata` out 32: fetched word.
- `data_sram_req/wr/size/addr/wstrb/wdata` in 1/1/2/32/4/32: load/store request.
- `data_sram_addr_ok`, `data_sram_data_ok` out 1; `data_sram_rdata` out 32.
- `arid` out 4, `araddr` out 32, `arsize` out 3, `arvalid` out 1, `arready` in 1.
- `arlen/arburst/arlock/arcache/arprot` out 8/2/2/4/3: constants 0/1/0/0/0.
- `rid` in 4, `rdata` in 32, `rresp` in 2 (ignored), `rlast` in 1 (ignored), `rvalid` in 1, `rready` out 1.
- `awid` out 4 (constant 1), `awaddr` out 32, `awsize` out 3, `awvalid` out 1, `awready` in 1.
- `awlen/awburst/awlock/awcache/awprot` out: same constants as the read channel.
- `wid` out 4 (constant 1), `wdata` out 32, `wstrb` out 4, `wlast` out 1 (constant 1), `wvalid` out 1, `wready` in 1.
- `bid` in 4, `bresp` in 2 (ignored), `bvalid` in 1, `bready` out 1.

## Operation
- IDs: `ID_INST`=0, `ID_DATA`=1. Single-beat transfers only. `arsize`/`awsize` = {1'b0, size}.
- Outstanding limits:
  - Instruction port: at most one outstanding read.
  - Data port: at most one outstanding transaction, read or write.
  - Read-data routing by `rid` is therefore unambiguous.
- Read FSM `RD_IDLE -> RD_ADDR -> RD_IDLE`:
  - In RD_IDLE, accept one read. Data read has priority over instruction read.
  - `addr_ok` is asserted to the winner only.
  - On acceptance, register addr, size and id, then go to RD_ADDR.
  - RD_ADDR holds `arvalid`=1 with stable fields until `arready`, then returns to RD_IDLE.
- Write FSM `WR_IDLE -> WR_SEND -> WR_RESP -> WR_IDLE`:
  - In WR_IDLE, a data write is accepted (`data_sram_addr_ok`=1) only when the data port has nothing outstanding. Register addr, size, wstrb and wdata.
  - WR_SEND drives `awvalid` and `wvalid` together. Each drops independently on its own handshake, tracked by flags `aw_done`/`w_done`. Exit when both are done.
  - WR_RESP waits for `bvalid`.
- `rready`=1 and `bready`=1 permanently.
- Return path:
  - `inst_sram_data_ok` = `rvalid && rid==ID_INST`.
  - `data_sram_data_ok` = `(rvalid && rid==ID_DATA) || (bvalid && state==WR_RESP)`.
  - `*_rdata` = `rdata` as a combinational pass-through.
- Read-after-write hazard:
  - A read whose addr[31:2] equals a pending write's addr[31:2] (WR_SEND or WR_RESP) gets no `addr_ok` until the write reaches WR_IDLE.
- Boundaries:
  - Instruction and data reads requested in the same cycle: data wins; instruction retries next idle cycle.
  - Data read and data write are never in flight together (one-outstanding rule).
  - `rvalid` and `bvalid` in the same cycle: both are consumed. Data-port conflict cannot occur, by construction.
  - Reset mid-transaction: all FSMs go to IDLE, flags and outstanding counters clear. The AXI slave is reset in the same cycle.

## Timing
- Reset values: all `*valid`=0, `*_addr_ok`=0, `*_data_ok`=0, registered addr/data=0.
- `addr_ok` is combinational in the same cycle as `req`.
- `arvalid`/`awvalid`/`wvalid` rise the cycle after `addr_ok`. They never depend combinationally on `*ready`.
- Minimum read latency: req at cycle 0, `arvalid` at cycle 1, `arready` at cycle 1, `rvalid` and `data_ok` at cycle 2.
- Minimum write latency: req at 0, aw/w at 1, `bvalid` and `data_ok` at 2.
- A new read can be accepted in the cycle after the `arready` handshake.

## Configuration
- `BRIDGE_RAW_ADDR_CHECK_EN` defined: reads stall only on a word-address match with the pending write.
- Undefined: every read stalls while the write FSM is not in WR_IDLE. This is conservative, smaller and address-independent.

## Structure
- `mycpu.h` holds:
  - `ID_INST`/`ID_DATA`;
  - the RD_*/WR_* state encodings;
  - the fixed AXI attribute constants.
- Sub-module `bridge_wr_ch` holds the write FSM and the `aw_done`/`w_done` flags. It exports its busy state and pending address for the hazard check.
- Read arbitration and return routing stay in the top-level module.

## Test plan
- Instruction read 0x1c000000, `arready` immediate, `rvalid` with rid 0 and data 0x02800c0c the next cycle → `inst_sram_data_ok`=1 with rdata 0x02800c0c, two cycles after req.
- Instruction and data reads in the same cycle → data `addr_ok`=1, `arid`=1 first. Instruction `addr_ok` follows in the cycle after that `arready`.
- Data write to 0x100 with wstrb 0xF, `awready` 2 cycles late and `wready` immediate → `wvalid` drops after 1 cycle; `awvalid` holds 3 cycles; `data_ok` on `bvalid`.
- Write to 0x100 pending, then a data read of 0x100 and an instruction read of 0x200 → 0x100 read stalls until `bvalid`. 0x200 proceeds only with the macro defined.
- `arready` held low for 5 cycles → `araddr`/`arid`/`arsize` stable and `arvalid`=1 throughout.
- Reset asserted in WR_SEND → next cycle all valids are 0, both FSMs are IDLE, and no spurious `data_ok` follows.
